// File: rtl/i2s_pkg.sv
// Shared I2S definitions: serializer state encoding and default frame widths.
// The width defaults match the clock generator's bits-per-WS-half-frame.
package i2s_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

  localparam int I2S_DATA_WIDTH = 24;
  localparam int I2S_SLOT_BITS  = 24;

endpackage

// File: rtl/i2s_edge_detect.sv
// BCLK falling-edge and WS transition detector in the clk_ref domain.
// clk_bit/clk_ws arrive already registered by the clock generator, so no
// extra synchronizer stages are needed here. WS is only evaluated on a BCLK
// fall because the generator moves WS on that same edge.
module i2s_edge_detect (
  input  logic clk_ref,
  input  logic reset,
  input  logic clk_bit,
  input  logic clk_ws,
  output logic fe,
  output logic ws_rise,
  output logic ws_fall
);

  logic bclk_d;
  logic ws_last;

  assign fe      = bclk_d & ~clk_bit;
  assign ws_rise = fe & ~ws_last & clk_ws;
  assign ws_fall = fe & ws_last & ~clk_ws;

  // Remember last BCLK level every cycle, last WS level only on BCLK falls.
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      bclk_d  <= 1'b0;
      ws_last <= 1'b0;
    end else begin
      bclk_d <= clk_bit;
      if (fe) begin
        ws_last <= clk_ws;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Stereo I2S (Philips format) transmit serializer.
// Takes one L/R pair per frame through a single-entry holding buffer and
// shifts it MSB-first onto i2s_sdata, one bit per BCLK fall. The data lags
// each WS edge by one BCLK because the slot's MSB is loaded into the shift
// register on the WS edge and only reaches the pin on the following fall.
//
// Handshake: a pair transfers on any clk_ref rising edge where
// sample_valid & sample_ready are both high; sample_ready is simply "buffer
// not full" and does not depend on sample_valid. The buffer is consumed on
// the BCLK fall where WS goes 1->0, and sample_ready returns the cycle after.
//
// SLOT_BITS must be >= DATA_WIDTH; the trailing SLOT_BITS-DATA_WIDTH bits of
// each slot are sent as zero.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH,
  parameter int SLOT_BITS  = I2S_SLOT_BITS
) (
  input  logic                  clk_ref,
  input  logic                  reset,
  input  logic                  clk_bit,
  input  logic                  clk_ws,
  input  logic [DATA_WIDTH-1:0] sample_left,
  input  logic [DATA_WIDTH-1:0] sample_right,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  i2s_sdata,
  output logic                  underrun,
  output logic                  active
);

  localparam int PAD = SLOT_BITS - DATA_WIDTH;

  i2s_state_t state;
  i2s_state_t state_next;

  logic                  fe;
  logic                  ws_rise;
  logic                  ws_fall;
  logic                  running;
  logic                  full;
  logic                  accept;
  logic                  consume;
  logic [DATA_WIDTH-1:0] left_buf;
  logic [DATA_WIDTH-1:0] right_buf;
  logic [DATA_WIDTH-1:0] right_hold;
  logic [SLOT_BITS-1:0]  shreg;
  logic [SLOT_BITS-1:0]  left_aligned;
  logic [SLOT_BITS-1:0]  right_aligned;

  i2s_edge_detect u_edge (
    .clk_ref (clk_ref),
    .reset   (reset),
    .clk_bit (clk_bit),
    .clk_ws  (clk_ws),
    .fe      (fe),
    .ws_rise (ws_rise),
    .ws_fall (ws_fall)
  );

  assign running = (state == RUN);
  assign accept  = sample_valid & ~full;
  // A new frame always starts on a WS fall; the IDLE->RUN edge counts too.
  assign consume = ws_fall & full;

  // Words sit at the top of the slot so padding bits shift out last.
  assign left_aligned  = SLOT_BITS'(left_buf) << PAD;
  assign right_aligned = SLOT_BITS'(right_hold) << PAD;

  assign sample_ready = ~full;
  assign active       = running;
  assign underrun     = ws_fall & ~full;

  // State register.
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: lock onto the first start-of-left-slot, then stay running.
  always_comb begin
    state_next = state;
    if ((state == IDLE) && ws_fall) begin
      state_next = RUN;
    end
  end

  // Single-entry holding buffer; consume and accept never coincide.
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      full      <= 1'b0;
      left_buf  <= '0;
      right_buf <= '0;
    end else if (consume) begin
      full <= 1'b0;
    end else if (accept) begin
      full      <= 1'b1;
      left_buf  <= sample_left;
      right_buf <= sample_right;
    end
  end

  // Shift engine: pin takes the old top bit, then load beats shift.
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      right_hold <= '0;
      i2s_sdata  <= 1'b0;
    end else if (fe) begin
      if (running) begin
        i2s_sdata <= shreg[SLOT_BITS-1];
      end
      if (ws_fall) begin
        shreg      <= full ? left_aligned : '0;
        right_hold <= full ? right_buf : '0;
      end else if (running && ws_rise) begin
        shreg <= right_aligned;
      end else if (running) begin
        shreg <= shreg << 1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: a 24/24 instance (dut) and a 24/32
// instance (dut_b) share one BCLK model; bits are captured on BCLK rises.
module tb_i2s_tx_serializer;

  localparam int HP = 3;  // BCLK half-period in clk_ref cycles

  logic        clk_ref;
  logic        reset;
  logic        clk_bit;
  logic        clk_ws24;
  logic        clk_ws32;
  logic [23:0] sample_left;
  logic [23:0] sample_right;
  logic        sample_valid;
  logic        sample_valid_b;
  logic        ready_a, ready_b;
  logic        sdata_a, sdata_b;
  logic        ur_a, ur_b;
  logic        act_a, act_b;

  int          n_cmp;
  int          n_fail;
  logic [47:0] exp_q[$];

  int          hp_cnt, bit24, bit32;
  logic        prev_bit, prev_ws24, prev_ws32;
  logic        rise, fall_a, fall_b, rise_a;
  int          ur_cnt, ur_off, sd_ones, n_acc, rdy_hi;
  logic        auto_inc;

  i2s_tx_serializer #(.DATA_WIDTH(24), .SLOT_BITS(24)) dut (
    .clk_ref      (clk_ref),
    .reset        (reset),
    .clk_bit      (clk_bit),
    .clk_ws       (clk_ws24),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (ready_a),
    .i2s_sdata    (sdata_a),
    .underrun     (ur_a),
    .active       (act_a)
  );

  i2s_tx_serializer #(.DATA_WIDTH(24), .SLOT_BITS(32)) dut_b (
    .clk_ref      (clk_ref),
    .reset        (reset),
    .clk_bit      (clk_bit),
    .clk_ws       (clk_ws32),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid_b),
    .sample_ready (ready_b),
    .i2s_sdata    (sdata_b),
    .underrun     (ur_b),
    .active       (act_b)
  );

  // Clock and reset block
  initial begin
    clk_ref = 1'b0;
    forever #5 clk_ref = ~clk_ref;
  end

  // BCLK/WS model: WS toggles on a BCLK fall every slot-length of bits.
  initial begin
    clk_bit  = 1'b0;
    clk_ws24 = 1'b0;
    clk_ws32 = 1'b0;
    hp_cnt   = 0;
    bit24    = 0;
    bit32    = 0;
    forever begin
      @(negedge clk_ref);
      hp_cnt++;
      if (hp_cnt == HP) begin
        hp_cnt = 0;
        if (clk_bit) begin
          clk_bit = 1'b0;
          bit24++;
          bit32++;
          if (bit24 == 24) begin
            bit24    = 0;
            clk_ws24 = ~clk_ws24;
          end
          if (bit32 == 32) begin
            bit32    = 0;
            clk_ws32 = ~clk_ws32;
          end
        end else begin
          clk_bit = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk_ref cycle; samples 2 time units after the falling edge.
  task automatic step();
    logic acc;
    acc = sample_valid & ready_a;
    if (acc) begin
      exp_q.push_back({sample_left, sample_right});
      n_acc++;
    end
    if (auto_inc && ready_a) rdy_hi++;
    @(negedge clk_ref);
    #2;
    rise   = clk_bit & ~prev_bit;
    fall_a = prev_ws24 & ~clk_ws24;
    rise_a = ~prev_ws24 & clk_ws24;
    fall_b = prev_ws32 & ~clk_ws32;
    if (ur_a) begin
      ur_cnt++;
      if (!fall_a) ur_off++;
    end
    if (sdata_a) sd_ones++;
    if (auto_inc && acc) begin
      sample_left++;
      sample_right++;
    end
    prev_bit  = clk_bit;
    prev_ws24 = clk_ws24;
    prev_ws32 = clk_ws32;
  endtask

  task automatic wait_rise();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 4 * HP + 4; i++) begin
      step();
      if (rise) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("bclk_rise_timeout", 64'(got), 64'd1);
  endtask

  // which: 0 = dut WS fall, 1 = dut_b WS fall, 2 = dut WS rise
  task automatic wait_ws(input int which, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if ((which == 0 && fall_a) || (which == 1 && fall_b) || (which == 2 && rise_a)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check($sformatf("ws_wait_timeout_%0d", which), 64'(got), 64'd1);
  endtask

  task automatic capture(input bit use_b, input int nbits, output logic [31:0] w);
    w = '0;
    for (int k = 0; k < nbits; k++) begin
      wait_rise();
      w = {w[30:0], (use_b ? sdata_b : sdata_a)};
    end
  endtask

  // Directed sequence
  initial begin
    logic [31:0] l, r;
    logic [47:0] e;
    n_cmp = 0; n_fail = 0;
    reset = 1'b1;
    sample_valid = 1'b0; sample_valid_b = 1'b0;
    sample_left = '0; sample_right = '0;
    prev_bit = 1'b0; prev_ws24 = 1'b0; prev_ws32 = 1'b0;
    rise = 1'b0; fall_a = 1'b0; fall_b = 1'b0; rise_a = 1'b0;
    ur_cnt = 0; ur_off = 0; sd_ones = 0; n_acc = 0; rdy_hi = 0;
    auto_inc = 1'b0;

    // Reset values
    repeat (3) step();
    check("rst_sdata", 64'(sdata_a), 64'd0);
    check("rst_underrun", 64'(ur_a), 64'd0);
    check("rst_active", 64'(act_a), 64'd0);
    check("rst_ready", 64'(ready_a), 64'd1);
    check("rst_ready_b", 64'(ready_b), 64'd1);

    // Release reset during a right slot, preload a pair
    for (int i = 0; i < 400; i++) begin
      step();
      if (clk_ws24) break;
    end
    check("ws_high_before_release", 64'(clk_ws24), 64'd1);
    reset = 1'b0;
    step();
    sample_left = 24'hA5F00F; sample_right = 24'h5A0FF0; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("ready_low_when_full", 64'(ready_a), 64'd0);
    sd_ones = 0;
    wait_ws(0, 400);
    check("idle_sdata_zero", 64'(sd_ones), 64'd0);
    check("active_low_before_lock", 64'(act_a), 64'd0);
    check("no_underrun_first_frame", 64'(ur_a), 64'd0);
    check("ready_low_on_consume_cycle", 64'(ready_a), 64'd0);
    step();
    check("active_after_lock", 64'(act_a), 64'd1);
    check("ready_after_consume", 64'(ready_a), 64'd1);

    // First frame bits
    capture(1'b0, 1, l);
    check("first_rise_prev_lsb", 64'(l), 64'd0);
    capture(1'b0, 24, l);
    capture(1'b0, 24, r);
    check("p1_left", 64'(l), 64'hA5F00F);
    check("p1_right", 64'(r), 64'h5A0FF0);

    // Starved frames: zeros and one underrun per WS fall
    ur_cnt = 0; ur_off = 0; sd_ones = 0;
    for (int f = 0; f < 3; f++) wait_ws(0, 400);
    check("underrun_per_frame", 64'(ur_cnt), 64'd3);
    check("underrun_only_on_ws_fall", 64'(ur_off), 64'd0);
    check("starved_sdata_zero", 64'(sd_ones), 64'd0);
    check("stays_active", 64'(act_a), 64'd1);

    // Streaming: valid held high with incrementing words
    exp_q.delete();
    n_acc = 0; rdy_hi = 0;
    sample_left = 24'h100000; sample_right = 24'hF00000;
    sample_valid = 1'b1; auto_inc = 1'b1;
    capture(1'b0, 1, l);
    capture(1'b0, 24, l);
    capture(1'b0, 24, r);
    check("stream_uf_left", 64'(l), 64'd0);
    check("stream_uf_right", 64'(r), 64'd0);
    for (int f = 0; f < 3; f++) begin
      capture(1'b0, 24, l);
      capture(1'b0, 24, r);
      check($sformatf("stream_exp_avail_%0d", f), 64'(exp_q.size() > 0), 64'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check($sformatf("stream_pair_%0d", f), {16'h0, l[23:0], r[23:0]}, 64'(e));
    end
    check("stream_accept_count", 64'(n_acc), 64'd5);
    check("stream_queue_left", 64'(exp_q.size()), 64'd2);
    check("stream_ready_cycles", 64'(rdy_hi), 64'd5);
    sample_valid = 1'b0; auto_inc = 1'b0;

    // 32-bit slot instance: 24 data bits then 8 zeros per slot
    wait_ws(1, 500);
    sample_left = 24'h3C5A96; sample_right = 24'hC3A569; sample_valid_b = 1'b1;
    step();
    sample_valid_b = 1'b0;
    check("b_ready_low_when_full", 64'(ready_b), 64'd0);
    wait_ws(1, 500);
    capture(1'b1, 1, l);
    capture(1'b1, 32, l);
    capture(1'b1, 32, r);
    check("b_left_padded", 64'(l), 64'h3C5A9600);
    check("b_right_padded", 64'(r), 64'hC3A56900);

    // Reset in the middle of a right slot, then resume with a fresh pair
    wait_ws(2, 400);
    repeat (20) step();
    reset = 1'b1;
    #1;
    check("midrst_sdata", 64'(sdata_a), 64'd0);
    check("midrst_active", 64'(act_a), 64'd0);
    check("midrst_underrun", 64'(ur_a), 64'd0);
    check("midrst_ready", 64'(ready_a), 64'd1);
    step();
    reset = 1'b0;
    sample_left = 24'h13579B; sample_right = 24'h2468AC; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    wait_ws(0, 400);
    check("resume_active_low_at_lock", 64'(act_a), 64'd0);
    check("resume_no_underrun", 64'(ur_a), 64'd0);
    capture(1'b0, 1, l);
    capture(1'b0, 24, l);
    capture(1'b0, 24, r);
    check("resume_left", 64'(l), 64'h13579B);
    check("resume_right", 64'(r), 64'h2468AC);
    check("resume_active", 64'(act_a), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Stereo I2S transmit serializer that sits directly downstream of the team's I2S clock generator (44.1 kHz wizard). It accepts left/right PCM sample pairs over a valid/ready handshake, buffers one pair, and shifts them out MSB-first on `i2s_sdata` in Philips I2S format. Changes are aligned to the generator's `clk_bit`/`clk_ws` levels, which this block samples in the `clk_ref` domain. Its output pins feed the external DAC together with the generator's clocks.

## Interface
- `DATA_WIDTH`, 24: bits per channel sample.
- `SLOT_BITS`, 24: BCLK periods per WS half-frame; must be ≥ DATA_WIDTH. Bits beyond DATA_WIDTH are sent as 0.
- `clk_ref`  in  1  system clock; same clock that drives the I2S clock generator.
- `reset`  in  1  asynchronous, active-high reset.
- `clk_bit`  in  1  BCLK level from the clock generator, registered in `clk_ref`.
- `clk_ws`  in  1  WS level from the clock generator: 0 = left, 1 = right.
- `sample_left`  in  DATA_WIDTH  left PCM word, two's complement.
- `sample_right`  in  DATA_WIDTH  right PCM word.
- `sample_valid`  in  1  a sample pair is presented.
- `sample_ready`  out  1  the holding buffer can accept a pair.
- `i2s_sdata`  out  1  serial data to the DAC.
- `underrun`  out  1  one-cycle pulse: a frame started with the buffer empty.
- `active`  out  1  high once frame-aligned (RUN state).

## Operation
- Edge detect: a register `bclk_d` holds the previous `clk_bit`. A falling event (`fe`) is `bclk_d & ~clk_bit`. All serializer actions happen only on `fe` cycles.
- WS tracking: a register `ws_last` holds the `clk_ws` value sampled at the previous `fe`. A WS change is `clk_ws != ws_last` on an `fe` cycle. The generator updates WS on the same edge that BCLK falls, so the new WS value is visible on the `fe` cycle.
- Holding buffer:
  - One entry, holding L and R.
  - `sample_ready = ~full`.
  - A pair is accepted when `sample_valid & sample_ready`. The buffer sets full the next cycle.
  - When full and the buffer is consumed in the same cycle, no new pair is accepted in that cycle.
- States:
  - IDLE: `i2s_sdata` = 0 and `active` = 0. The buffer may fill.
  - IDLE → RUN on the first `fe` where WS goes 1→0 (start of the left slot).
  - RUN stays in RUN until reset.
- On each `fe` in RUN:
  - `i2s_sdata <= shreg[SLOT_BITS-1]`, then `shreg <<= 1` (0 fills in at the bottom).
  - If WS goes 1→0 and the buffer is full: `shreg` loads `{sample_left, zeros}`, `right_hold` loads `sample_right`, and full clears.
  - If WS goes 1→0 and the buffer is empty: `shreg` and `right_hold` load 0 and `underrun` pulses.
  - If WS goes 0→1: `shreg` loads `{right_hold, zeros}`.
  - The load takes precedence over the shift in `shreg`. `i2s_sdata` still takes the old top bit, which is the LSB of the previous slot.
- Result: the MSB appears on the `fe` one BCLK after the WS change. This is the standard I2S one-bit delay.
- The IDLE→RUN transition `fe` performs the same load as a 1→0 change.
- Reset, asynchronous and valid mid-frame, clears everything:
  - State → IDLE; `shreg`, `right_hold`, and full → 0.
  - `bclk_d`, `ws_last` → 0.
  - `i2s_sdata`, `underrun`, `active` → 0; `sample_ready` → 1.

## Timing
- `i2s_sdata` updates exactly one `clk_ref` cycle after `clk_bit` falls. Setup to the DAC's BCLK rise is the BCLK half-period minus one cycle.
- Required: BCLK half-period ≥ 2 `clk_ref` cycles (the default generator gives 24).
- Latency from a pair being accepted to its left MSB on the pin: up to one full frame plus one BCLK.
- Throughput: one pair per frame (2·SLOT_BITS BCLK periods).
- `underrun` is high for exactly one `clk_ref` cycle, on the `fe` cycle.
- `sample_ready` rises the cycle after the consume.

## Structure
- A shared package `i2s_pkg` holds:
  - the `i2s_state_t` enum (IDLE, RUN);
  - default width constants `I2S_DATA_WIDTH = 24` and `I2S_SLOT_BITS = 24`, which are shared with the clock generator's `I2S_WS_NBITS`.
- One natural sub-module is `i2s_edge_detect`, containing the BCLK fall and WS change registers with `fe` / `ws_rise` / `ws_fall` outputs. It is reusable by a future I2S receiver.

## Test plan
- Reset released while WS = 1, then WS falls → `active` rises on that `fe`. `i2s_sdata` stays 0 before it.
- Push L = 24'hA5F00F, R = 24'h5A0FF0 before the first frame → bits captured on BCLK rises equal A5F00F in the left slot and 5A0FF0 in the right slot, MSB one BCLK after each WS edge.
- No pair ever pushed → sdata is all zeros and `underrun` pulses once per frame, on each WS 1→0.
- `sample_valid` held high with incrementing data → exactly one pair accepted per frame, `sample_ready` low between consumes, no word skipped or duplicated.
- SLOT_BITS = 32, DATA_WIDTH = 24 → 24 data bits followed by 8 zeros per slot; LSB of previous slot appears in first BCLK of the next slot.
- Assert reset mid-right-slot → all outputs return to their reset values immediately. Block resumes on the next WS 1→0 with the freshly pushed pair.
